nios_system_gpio_pio_v2: RTL and testbench

//  Parametrised Avalon-MM GPIO port; next generation of the RFFE GPIO PIO.

---
 rtl/nios_system_gpio_pio_v2.sv | 190 +++++++++++++++++++
 tb/tb_nios_system_gpio_pio_v2.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_gpio_pio_v2.sv
// nios_system_gpio_pio_v2
// Avalon-MM GPIO slave: WIDTH output bits with atomic set/clear/toggle,
// synchronised inputs and a maskable, registered interrupt.
// Build option GPIO_EDGE_CAPTURE_EN: when defined, the interrupt comes from
// per-bit rising/falling edge capture (EDGE/ETYPE registers). When undefined,
// the interrupt is level-sensitive on the synchronised inputs and EDGE/ETYPE
// read as zero.
module nios_system_gpio_pio_v2 #(
  parameter int unsigned WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h00018000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    A_DATA   = 3'd0,
    A_OUT    = 3'd1,
    A_MASK   = 3'd2,
    A_EDGE   = 3'd3,
    A_SET    = 3'd4,
    A_CLR    = 3'd5,
    A_ETYPE  = 3'd6,
    A_TOGGLE = 3'd7
  } reg_addr_e;

  localparam logic [WIDTH-1:0] LP_OUT_RST = RESET_VALUE[WIDTH-1:0];

  reg_addr_e                          w_addr;
  logic                               w_wr;
  logic [WIDTH-1:0]                   w_wd;
  logic [WIDTH-1:0]                   w_s;
  logic [WIDTH-1:0]                   w_src;
  logic [WIDTH-1:0]                   w_edge_rd;
  logic [WIDTH-1:0]                   w_etype_rd;
  logic [31:0]                        w_rd;

  logic [SYNC_STAGES-1:0][WIDTH-1:0]  r_sync;
  logic [WIDTH-1:0]                   r_out;
  logic [WIDTH-1:0]                   r_mask;
  logic [31:0]                        r_rd;
  logic                               r_irq;

  assign w_addr = reg_addr_e'(address);
  assign w_wr   = chipselect & ~write_n;
  assign w_wd   = writedata[WIDTH-1:0];
  assign w_s    = r_sync[SYNC_STAGES-1];

  // Input synchroniser chain; the last stage is the sampled pin value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
  end

  // Output register with direct, set, clear and toggle write ports
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= LP_OUT_RST;
    end else if (w_wr) begin
      case (w_addr)
        A_DATA, A_OUT: r_out <= w_wd;
        A_SET:         r_out <= r_out | w_wd;
        A_CLR:         r_out <= r_out & ~w_wd;
        A_TOGGLE:      r_out <= r_out ^ w_wd;
        default:       ;
      endcase
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
    end else if (w_wr && (w_addr == A_MASK)) begin
      r_mask <= w_wd;
    end
  end

`ifdef GPIO_EDGE_CAPTURE_EN
  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [WIDTH-1:0] r_hist;
  logic [WIDTH-1:0] r_etype;
  logic [WIDTH-1:0] r_edge;
  logic [ARM_W-1:0] r_arm;
  logic             w_armed;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_w1c;

  // Edges are ignored until the synchroniser and history flop have refilled
  // after reset, so pins already high at reset do not look like rising edges.
  assign w_armed = (r_arm == ARM_W'(ARM_CYCLES));
  assign w_ev    = w_armed ? ((w_s & ~r_hist & ~r_etype) | (~w_s & r_hist & r_etype))
                           : '0;
  assign w_w1c   = (w_wr && (w_addr == A_EDGE)) ? w_wd : '0;

  // Post-reset arming counter, saturates once armed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arm <= '0;
    end else if (!w_armed) begin
      r_arm <= r_arm + ARM_W'(1);
    end
  end

  // Edge history flop, one cycle behind the synchronised input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
    end else begin
      r_hist <= w_s;
    end
  end

  // Per-bit edge polarity select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_etype <= '0;
    end else if (w_wr && (w_addr == A_ETYPE)) begin
      r_etype <= w_wd;
    end
  end

  // Sticky edge capture; a new event beats a same-cycle write-1-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_w1c) | w_ev;
    end
  end

  assign w_src      = r_edge;
  assign w_edge_rd  = r_edge;
  assign w_etype_rd = r_etype;
`else
  assign w_src      = w_s;
  assign w_edge_rd  = '0;
  assign w_etype_rd = '0;
`endif

  // Read mux; unused upper bits stay zero
  always_comb begin
    w_rd = '0;
    case (w_addr)
      A_DATA:  w_rd[WIDTH-1:0] = w_s;
      A_OUT:   w_rd[WIDTH-1:0] = r_out;
      A_MASK:  w_rd[WIDTH-1:0] = r_mask;
      A_EDGE:  w_rd[WIDTH-1:0] = w_edge_rd;
      A_ETYPE: w_rd[WIDTH-1:0] = w_etype_rd;
      default: w_rd = '0;
    endcase
  end

  // Registered read data, refreshed every clock regardless of chipselect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd <= '0;
    end else begin
      r_rd <= w_rd;
    end
  end

  // Registered interrupt request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_src & r_mask);
    end
  end

  assign out_port = r_out;
  assign readdata = r_rd;
  assign irq      = r_irq;

endmodule

// File: tb/tb_nios_system_gpio_pio_v2.sv
// Testbench for nios_system_gpio_pio_v2 (WIDTH = 32, SYNC_STAGES = 2).
// A behavioural model tracks pin history as a queue and derives register
// contents from the register-map rules; a single compare process checks
// every negedge, plus literal expectations that also pin the model.
module tb_nios_system_gpio_pio_v2;

  localparam int          SS = 2;
  localparam logic [31:0] RV = 32'h00018000;
`ifdef GPIO_EDGE_CAPTURE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic        irq;

  nios_system_gpio_pio_v2 #(
    .WIDTH       (32),
    .RESET_VALUE (RV),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_out, m_mask, m_edge, m_etype, m_rd;
  logic        m_irq;
  logic [31:0] m_pins[$];   // pin values sampled at each edge, newest first
  int          m_edges;     // clock edges seen since reset released
  logic [31:0] t_s, t_p, t_src, t_ev, t_w1c, t_rd;
  logic        t_irq, t_wr;

  function automatic logic [31:0] pin_ago(input int k);
    if (k < m_pins.size()) return m_pins[k];
    return 32'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out = RV; m_mask = '0; m_edge = '0; m_etype = '0;
      m_rd = '0; m_irq = 1'b0; m_pins = {}; m_edges = 0;
    end else begin
      // the synchronised value lags the pin by SS edges; history one more
      t_s   = pin_ago(SS - 1);
      t_p   = pin_ago(SS);
      t_src = EDGE_EN ? m_edge : t_s;
      t_irq = |(t_src & m_mask);
      case (address)
        3'd0:    t_rd = t_s;
        3'd1:    t_rd = m_out;
        3'd2:    t_rd = m_mask;
        3'd3:    t_rd = m_edge;
        3'd6:    t_rd = m_etype;
        default: t_rd = 32'h0;
      endcase
      t_wr  = chipselect && !write_n;
      t_ev  = (m_edges >= SS + 1) ? ((t_s & ~t_p & ~m_etype) | (~t_s & t_p & m_etype)) : 32'h0;
      t_w1c = (t_wr && address == 3'd3) ? writedata : 32'h0;
      if (EDGE_EN) m_edge = (m_edge & ~t_w1c) | t_ev;
      if (t_wr) begin
        case (address)
          3'd0, 3'd1: m_out = writedata;
          3'd2:       m_mask = writedata;
          3'd4:       m_out = m_out | writedata;
          3'd5:       m_out = m_out & ~writedata;
          3'd6:       if (EDGE_EN) m_etype = writedata;
          3'd7:       m_out = m_out ^ writedata;
          default:    ;
        endcase
      end
      m_rd  = t_rd;
      m_irq = t_irq;
      m_pins.push_front(in_port);
      if (m_pins.size() > SS + 2) void'(m_pins.pop_back());
      m_edges++;
    end
  end

  // ---------------- compare process ----------------
  int n_pass = 0;
  int n_total = 0;
  logic        lit_out_en = 1'b0, lit_rd_en = 1'b0, lit_irq_en = 1'b0;
  logic [31:0] lit_out, lit_rd;
  logic        lit_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    chk("out_port", out_port, m_out);
    chk("readdata", readdata, m_rd);
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
    if (lit_out_en) begin
      chk("lit_out_port", out_port, lit_out);
      chk("lit_model_out", m_out, lit_out);
    end
    if (lit_rd_en) begin
      chk("lit_readdata", readdata, lit_rd);
      chk("lit_model_rd", m_rd, lit_rd);
    end
    if (lit_irq_en) begin
      chk("lit_irq", {31'h0, irq}, {31'h0, lit_irq});
      chk("lit_model_irq", {31'h0, m_irq}, {31'h0, lit_irq});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    cyc(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic lit_wait;
    @(negedge clk);
    #1;
    lit_out_en = 1'b0; lit_rd_en = 1'b0; lit_irq_en = 1'b0;
  endtask

  task automatic exp_out(input logic [31:0] v); lit_out = v; lit_out_en = 1'b1; endtask
  task automatic exp_rd(input logic [31:0] v);  lit_rd = v;  lit_rd_en = 1'b1;  endtask
  task automatic exp_irq(input logic v);        lit_irq = v; lit_irq_en = 1'b1; endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_port = '0; chipselect = 1'b0; write_n = 1'b1;
    address = 3'd0; writedata = '0;
    #1 reset = 1'b1;
    cyc(2);
    exp_out(RV); exp_rd(32'h0); exp_irq(1'b0);
    lit_wait;
    cyc(1);
    reset = 1'b0;

    // atomic output operations
    wr(3'd4, 32'h0F);
    wr(3'd5, 32'h03);
    exp_out(32'h0001800C); lit_wait;
    wr(3'd7, 32'h81);
    exp_out(32'h0001808D); lit_wait;
    address = 3'd1; cyc(1);
    exp_rd(32'h0001808D); lit_wait;
    address = 3'd4; cyc(1);
    exp_rd(32'h0); lit_wait;

    // input synchroniser latency
    address = 3'd0; cyc(1);
    in_port = 32'h1;
    cyc(SS);
    exp_rd(32'h0); lit_wait;
    cyc(1);
    exp_rd(32'h1); lit_wait;
    in_port = 32'h0;
    cyc(4);

`ifdef GPIO_EDGE_CAPTURE_EN
    // rising-edge capture, irq, and write-1-to-clear
    wr(3'd3, 32'hFFFFFFFF);
    wr(3'd2, 32'h1);
    address = 3'd3; in_port = 32'h1;
    cyc(1);
    in_port = 32'h0;
    cyc(3);
    exp_irq(1'b1); exp_rd(32'h1); lit_wait;
    wr(3'd3, 32'h1);
    cyc(1);
    exp_irq(1'b0); exp_rd(32'h0); lit_wait;

    // W1C in the same cycle as a new rising edge: capture wins
    in_port = 32'h1;
    cyc(2);
    wr(3'd3, 32'h1);
    cyc(1);
    exp_rd(32'h1); exp_irq(1'b1); lit_wait;
    in_port = 32'h0;
    wr(3'd3, 32'h1);
    cyc(4);

    // pin high through reset: no capture once armed
    in_port = 32'h1;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    wr(3'd2, 32'h1);
    address = 3'd3;
    cyc(6);
    exp_rd(32'h0); exp_irq(1'b0); lit_wait;
    wr(3'd6, 32'h1);
    cyc(2);
    exp_rd(32'h0); lit_wait;
    address = 3'd6; cyc(1);
    exp_rd(32'h1); lit_wait;
    address = 3'd3;
    in_port = 32'h0;
    cyc(4);
    exp_rd(32'h1); exp_irq(1'b1); lit_wait;
`else
    // level-sensitive irq on bit 2
    wr(3'd2, 32'h4);
    in_port = 32'h4;
    cyc(3);
    exp_irq(1'b1); lit_wait;
    in_port = 32'h0;
    cyc(3);
    exp_irq(1'b0); lit_wait;
    wr(3'd3, 32'hFFFFFFFF);
    wr(3'd6, 32'hFFFFFFFF);
    address = 3'd3; cyc(1);
    exp_rd(32'h0); lit_wait;
    address = 3'd6; cyc(1);
    exp_rd(32'h0); lit_wait;
    in_port = 32'h4;
    cyc(3);
    exp_irq(1'b1); lit_wait;
`endif

    // asynchronous reset mid-operation drops irq before the next edge
    cyc(1);
    reset = 1'b1;
    exp_irq(1'b0); exp_out(RV); lit_wait;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
